led_shift_engine: RTL and testbench

Parametrised successor to the board's 8-bit LED shift register. It holds a WIDTH-bit LED pattern and advances it autonomously at a programmable step rate. It supports rotate, zero-fill shift and bounce (ping-pong) modes, with run/stop control and status outputs. It sits between the debounced button/switch decode and the LED pins, and generates its own step strobe from `clk`.

---
 rtl/led_shift_engine.sv | 91 +++++++++
 tb/tb_led_shift_engine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_engine.sv
// led_shift_engine: self-timed WIDTH-bit LED pattern engine with rotate, zero-fill and bounce modes
module led_shift_engine #(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_clear,
  input  logic             cmd_load,
  input  logic             cmd_left,
  input  logic             cmd_right,
  input  logic             cmd_stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] led,
  output logic             dir,
  output logic             running,
  output logic             step
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] led_nxt, step_led;
  logic dir_nxt, step_dir, step_nxt, tick;
  assign running = state == RUN;
  assign tick = running && cnt == CW'(STEP_DIV - 1);
  // next pattern if a step were taken this cycle
  always_comb begin
    step_led = led;
    step_dir = dir;
    if (mode == 2'b01) step_led = dir ? led << 1 : led >> 1;
    else if (mode == 2'b10) begin
      if (dir) begin
        if (!led[WIDTH-1]) step_led = led << 1;
        else if (!led[0]) begin
          step_led = led >> 1;
          step_dir = 1'b0;
        end
      end else begin
        if (!led[0]) step_led = led >> 1;
        else if (!led[WIDTH-1]) begin
          step_led = led << 1;
          step_dir = 1'b1;
        end
      end
    end else step_led = dir ? {led[WIDTH-2:0], led[WIDTH-1]} : {led[0], led[WIDTH-1:1]};
  end
  // commands pre-empt the step; a both-direction request falls through to it
  always_comb begin
    state_nxt = state;
    led_nxt = led;
    dir_nxt = dir;
    cnt_nxt = running ? (tick ? '0 : cnt + 1'b1) : '0;
    step_nxt = 1'b0;
    if (cmd_clear) begin
      led_nxt = '0;
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (cmd_load) begin
      led_nxt = d_in;
      cnt_nxt = '0;
    end else if (cmd_stop) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (cmd_left ^ cmd_right) begin
      dir_nxt = cmd_left;
      state_nxt = RUN;
      cnt_nxt = '0;
    end else if (tick) begin
      led_nxt = step_led;
      dir_nxt = step_dir;
      step_nxt = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      led <= '0;
      dir <= 1'b0;
      step <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      led <= led_nxt;
      dir <= dir_nxt;
      step <= step_nxt;
    end
  end
endmodule

// File: tb/tb_led_shift_engine.sv
// tb_led_shift_engine: directed scenario checks of led_shift_engine at WIDTH=8, STEP_DIV=4
module tb_led_shift_engine;
  logic clk = 1'b0, rst = 1'b0;
  logic cmd_clear = 1'b0, cmd_load = 1'b0, cmd_left = 1'b0, cmd_right = 1'b0, cmd_stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d_in = '0;
  logic [7:0] led;
  logic dir, running, step;
  int checks = 0, errors = 0;

  led_shift_engine #(.WIDTH(8), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd_clear(cmd_clear), .cmd_load(cmd_load), .cmd_left(cmd_left),
    .cmd_right(cmd_right), .cmd_stop(cmd_stop), .mode(mode), .d_in(d_in),
    .led(led), .dir(dir), .running(running), .step(step)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic c, input logic l, input logic lt, input logic rt, input logic s, input logic [7:0] d);
    cmd_clear = c; cmd_load = l; cmd_left = lt; cmd_right = rt; cmd_stop = s; d_in = d;
    cyc();
    cmd_clear = 0; cmd_load = 0; cmd_left = 0; cmd_right = 0; cmd_stop = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if ({led, dir, running, step} !== 11'b0) begin
      errors++;
      $display("FAIL reset: led=%b dir=%b running=%b step=%b expected all 0", led, dir, running, step);
    end
  endtask

  task automatic test_rotate;
    logic [7:0] exp_led [2] = '{8'b0000_0011, 8'b0000_0110};
    mode = 2'b00;
    pulse(0, 1, 0, 0, 0, 8'b1000_0001);
    checks++;
    if (led !== 8'b1000_0001 || running !== 1'b0) begin
      errors++;
      $display("FAIL rotate_load: led=%b running=%b expected 10000001 0", led, running);
    end
    pulse(0, 0, 1, 0, 0, 8'h00);
    checks++;
    if (running !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL rotate_start: running=%b dir=%b expected 1 1", running, dir);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(3);
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL rotate_early_step %0d: step=%b expected 0", i, step);
      end
      cyc();
      checks++;
      if (led !== exp_led[i] || step !== 1'b1) begin
        errors++;
        $display("FAIL rotate_step %0d: led=%b step=%b expected %b 1", i, led, step, exp_led[i]);
      end
    end
  endtask

  task automatic test_zero_fill;
    logic [7:0] exp_led [4] = '{8'b0000_0010, 8'b0000_0001, 8'b0000_0000, 8'b0000_0000};
    pulse(0, 0, 0, 0, 1, 8'h00);
    mode = 2'b01;
    pulse(0, 1, 0, 0, 0, 8'b0000_0101);
    pulse(0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc(4);
      checks++;
      if (led !== exp_led[i] || step !== 1'b1 || running !== 1'b1 || dir !== 1'b0) begin
        errors++;
        $display("FAIL zero_fill_step %0d: led=%b step=%b running=%b dir=%b expected %b 1 1 0",
                 i, led, step, running, dir, exp_led[i]);
      end
    end
  endtask

  task automatic test_bounce;
    pulse(0, 0, 0, 0, 1, 8'h00);
    mode = 2'b10;
    pulse(0, 1, 0, 0, 0, 8'b0100_0000);
    pulse(0, 0, 1, 0, 0, 8'h00);
    cyc(4);
    checks++;
    if (led !== 8'b1000_0000 || dir !== 1'b1 || step !== 1'b1) begin
      errors++;
      $display("FAIL bounce_step1: led=%b dir=%b step=%b expected 10000000 1 1", led, dir, step);
    end
    cyc(4);
    checks++;
    if (led !== 8'b0100_0000 || dir !== 1'b0 || step !== 1'b1) begin
      errors++;
      $display("FAIL bounce_step2: led=%b dir=%b step=%b expected 01000000 0 1", led, dir, step);
    end
    pulse(0, 1, 0, 0, 0, 8'b1000_0001);
    for (int i = 0; i < 2; i++) begin
      cyc(4);
      checks++;
      if (led !== 8'b1000_0001 || dir !== 1'b0 || step !== 1'b1 || running !== 1'b1) begin
        errors++;
        $display("FAIL bounce_hold %0d: led=%b dir=%b step=%b running=%b expected 10000001 0 1 1",
                 i, led, dir, step, running);
      end
    end
  endtask

  task automatic test_clear_load;
    pulse(1, 1, 0, 0, 0, 8'hFF);
    checks++;
    if (led !== 8'h00 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_over_load: led=%h running=%b expected 00 0", led, running);
    end
    mode = 2'b00;
    pulse(0, 0, 1, 0, 0, 8'h00);
    cyc();
    pulse(0, 1, 0, 0, 0, 8'h0F);
    checks++;
    if (led !== 8'h0F || step !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_running: led=%h step=%b running=%b expected 0f 0 1", led, step, running);
    end
    cyc(3);
    checks++;
    if (step !== 1'b0 || led !== 8'h0F) begin
      errors++;
      $display("FAIL load_restart_early: led=%h step=%b expected 0f 0", led, step);
    end
    cyc();
    checks++;
    if (led !== 8'h1E || step !== 1'b1) begin
      errors++;
      $display("FAIL load_restart_step: led=%h step=%b expected 1e 1", led, step);
    end
  endtask

  task automatic test_stop_both;
    pulse(0, 0, 0, 0, 1, 8'h00);
    pulse(0, 0, 1, 1, 0, 8'h00);
    checks++;
    if (running !== 1'b0 || led !== 8'h1E || dir !== 1'b1) begin
      errors++;
      $display("FAIL both_dirs: running=%b led=%h dir=%b expected 0 1e 1", running, led, dir);
    end
    pulse(0, 0, 0, 1, 0, 8'h00);
    checks++;
    if (running !== 1'b1 || dir !== 1'b0) begin
      errors++;
      $display("FAIL right_start: running=%b dir=%b expected 1 0", running, dir);
    end
    cyc(2);
    pulse(0, 0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (step !== 1'b0 || led !== 8'h1E || running !== 1'b0) begin
        errors++;
        $display("FAIL stop_frozen %0d: led=%h step=%b running=%b expected 1e 0 0", i, led, step, running);
      end
      cyc();
    end
  endtask

  task automatic test_rst_mid_run;
    pulse(0, 0, 1, 0, 0, 8'h00);
    cyc(2);
    rst = 1;
    cmd_load = 1;
    d_in = 8'hFF;
    cyc();
    rst = 0;
    cmd_load = 0;
    checks++;
    if ({led, dir, running, step} !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid_run: led=%b dir=%b running=%b step=%b expected all 0", led, dir, running, step);
    end
  endtask

  initial begin
    cyc();
    test_reset();
    test_rotate();
    test_zero_fill();
    test_bounce();
    test_clear_load();
    test_stop_both();
    test_rst_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
